// File: rtl/seg7_2_bin.sv
// seg7_2_bin: converts four captured 7-segment displays (display 3 most
// significant) into a 12-bit binary value. One digit is folded in per clock,
// starting from the most significant display. The result and its VALID/ERR
// pulse appear four edges after the accepted START.
// Optional build macro SEG7_2_BIN_SAT_EN: when defined, valid values above
// 4095 saturate to 0xFFF with no error. Otherwise they report ERR with OUT=0.
module seg7_2_bin (
    input  logic        CLK_i,
    input  logic        RST_i,
    input  logic        START_i,
    input  logic [3:0]  INa_i,
    input  logic [3:0]  INb_i,
    input  logic [3:0]  INc_i,
    input  logic [3:0]  INd_i,
    input  logic [3:0]  INe_i,
    input  logic [3:0]  INf_i,
    input  logic [3:0]  INg_i,
    output logic [11:0] OUT_o,
    output logic        VALID_o,
    output logic        ERR_o,
    output logic        BUSY_o
);

    typedef enum logic {
        IDLE = 1'b0,
        DEC  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q,   idx_d;
    logic [13:0] acc_q,   acc_d;
    logic        err_q,   err_d;
    logic [6:0]  seg_q [4];
    logic [6:0]  seg_d [4];
    logic [11:0] out_q,   out_d;
    logic        valid_q, valid_d;
    logic        eout_q,  eout_d;

    logic [6:0]  cur_pat;
    logic [4:0]  cur_dec;
    logic        dig_ok;
    logic [13:0] acc_mac;

    // Returns {valid, value}. Any pattern outside the ten glyphs is invalid.
    function automatic logic [4:0] decode_digit(input logic [6:0] pat);
        logic [4:0] r;
        case (pat)
            7'h3F:   r = 5'h10;
            7'h06:   r = 5'h11;
            7'h5B:   r = 5'h12;
            7'h4F:   r = 5'h13;
            7'h66:   r = 5'h14;
            7'h6D:   r = 5'h15;
            7'h7D:   r = 5'h16;
            7'h07:   r = 5'h17;
            7'h7F:   r = 5'h18;
            7'h6F:   r = 5'h19;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // Decode the digit selected by the index and fold it into the accumulator.
    // An invalid digit contributes 0, so the accumulator never exceeds 9999.
    always_comb begin
        cur_pat = seg_q[idx_q];
        cur_dec = decode_digit(cur_pat);
        dig_ok  = cur_dec[4];
        acc_mac = (acc_q * 14'd10) + {10'd0, cur_dec[3:0]};
    end

    // Next-state and output logic for the IDLE/DEC sequencer.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        err_d   = err_q;
        seg_d   = seg_q;
        out_d   = out_q;
        valid_d = 1'b0;
        eout_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (START_i) begin
                    for (int i = 0; i < 4; i++) begin
                        seg_d[i] = {INg_i[i], INf_i[i], INe_i[i], INd_i[i],
                                    INc_i[i], INb_i[i], INa_i[i]};
                    end
                    acc_d   = '0;
                    err_d   = 1'b0;
                    idx_d   = 2'd3;
                    state_d = DEC;
                end
            end
            DEC: begin
                acc_d = acc_mac;
                err_d = err_q | ~dig_ok;
                idx_d = idx_q - 2'd1;
                if (idx_q == 2'd0) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    if (err_q || !dig_ok) begin
                        out_d  = '0;
                        eout_d = 1'b1;
                    end else if (acc_mac > 14'd4095) begin
`ifdef SEG7_2_BIN_SAT_EN
                        out_d  = 12'hFFF;
                        eout_d = 1'b0;
`else
                        out_d  = '0;
                        eout_d = 1'b1;
`endif
                    end else begin
                        out_d  = acc_mac[11:0];
                        eout_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (RST_i) begin
            state_q <= IDLE;
            idx_q   <= 2'd3;
            acc_q   <= '0;
            err_q   <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
            eout_q  <= 1'b0;
            // NOTE: the capture registers are reset too, so no stale display data survives a reset.
            for (int i = 0; i < 4; i++) begin
                seg_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            eout_q  <= eout_d;
            seg_q   <= seg_d;
        end
    end

    assign OUT_o   = out_q;
    assign VALID_o = valid_q;
    assign ERR_o   = eout_q;
    assign BUSY_o  = (state_q == DEC);

endmodule

// File: tb/tb_seg7_2_bin.sv
// Self-checking bench for seg7_2_bin. A table of directed conversions is
// followed by hand-written sequences covering repeated START and mid-conversion reset.
module tb_seg7_2_bin;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  in_a, in_b, in_c, in_d, in_e, in_f, in_g;
    logic [11:0] out;
    logic        valid, err, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg7_2_bin dut (
        .CLK_i   (clk),
        .RST_i   (rst),
        .START_i (start),
        .INa_i   (in_a),
        .INb_i   (in_b),
        .INc_i   (in_c),
        .INd_i   (in_d),
        .INe_i   (in_e),
        .INf_i   (in_f),
        .INg_i   (in_g),
        .OUT_o   (out),
        .VALID_o (valid),
        .ERR_o   (err),
        .BUSY_o  (busy)
    );

    typedef struct {
        string           name;
        int              d3, d2, d1, d0;
        logic [11:0]     exp_out;
        logic            exp_err;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Codes 0..9 are the digit glyphs. 10 is blank, 11 is 0x7E and 12 is 0x08 (both invalid).
    function automatic logic [6:0] pat_of(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;
            3: return 7'h4F;  4: return 7'h66;  5: return 7'h6D;
            6: return 7'h7D;  7: return 7'h07;  8: return 7'h7F;
            9: return 7'h6F;  10: return 7'h00; 11: return 7'h7E;
            default: return 7'h08;
        endcase
    endfunction

    task automatic drive(input int d3, input int d2, input int d1, input int d0);
        logic [6:0] p [4];
        p[3] = pat_of(d3); p[2] = pat_of(d2); p[1] = pat_of(d1); p[0] = pat_of(d0);
        for (int i = 0; i < 4; i++) begin
            in_a[i] = p[i][0]; in_b[i] = p[i][1]; in_c[i] = p[i][2];
            in_d[i] = p[i][3]; in_e[i] = p[i][4]; in_f[i] = p[i][5];
            in_g[i] = p[i][6];
        end
    endtask

    // One full conversion with cycle-accurate checks, sampled on falling edges.
    task automatic convert(input vec_t v);
        logic [11:0] held;
        @(negedge clk);
        drive(v.d3, v.d2, v.d1, v.d0);
        start = 1'b1;
        @(negedge clk);                     // after edge k
        start = 1'b0;
        check({v.name, " busy@k"}, busy, 1);
        check({v.name, " valid@k"}, valid, 0);
        for (int c = 1; c <= 3; c++) begin
            drive(8, 8, 8, 8);              // later input changes must not matter
            @(negedge clk);
            check({v.name, " busy mid"}, busy, 1);
            check({v.name, " valid mid"}, valid, 0);
        end
        @(negedge clk);                     // after edge k+4
        check({v.name, " valid"}, valid, 1);
        check({v.name, " out"}, out, v.exp_out);
        check({v.name, " err"}, err, v.exp_err);
        check({v.name, " busy end"}, busy, 0);
        held = v.exp_out;
        @(negedge clk);
        check({v.name, " valid pulse"}, valid, 0);
        check({v.name, " err pulse"}, err, 0);
        check({v.name, " out hold"}, out, held);
    endtask

    initial begin
        logic       saw_valid;
        logic [11:0] ovf_out;
        logic        ovf_err;
`ifdef SEG7_2_BIN_SAT_EN
        ovf_out = 12'hFFF; ovf_err = 1'b0;
`else
        ovf_out = 12'h000; ovf_err = 1'b1;
`endif
        vecs[0] = '{"v1234",  1, 2, 3, 4,  12'h4D2, 1'b0};
        vecs[1] = '{"v0000",  0, 0, 0, 0,  12'h000, 1'b0};
        vecs[2] = '{"v4095",  4, 0, 9, 5,  12'hFFF, 1'b0};
        vecs[3] = '{"v9999",  9, 9, 9, 9,  ovf_out, ovf_err};
        vecs[4] = '{"v2048",  2, 0, 4, 8,  12'h800, 1'b0};
        vecs[5] = '{"v4096",  4, 0, 9, 6,  ovf_out, ovf_err};
        vecs[6] = '{"vblank1",5, 1, 10, 7, 12'h000, 1'b1};
        vecs[7] = '{"v0789",  0, 7, 8, 9,  12'h315, 1'b0};
        vecs[8] = '{"vbad3",  11, 7, 8, 9, 12'h000, 1'b1};
        vecs[9] = '{"vbad0",  3, 2, 1, 12, 12'h000, 1'b1};

        rst = 1'b1;
        start = 1'b0;
        drive(0, 0, 0, 0);
        #12;
        check("reset out", out, 0);
        check("reset valid", valid, 0);
        check("reset err", err, 0);
        check("reset busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            convert(vecs[i]);
        end

        // START held high across k+1..k+4 with changing inputs: one result from inputs at k.
        @(negedge clk);
        drive(1, 2, 3, 4);
        start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 3; c++) begin
            drive(9, 8, 7, 6 - c);
            @(negedge clk);
            check("rep busy", busy, 1);
            check("rep valid", valid, 0);
        end
        @(negedge clk);
        check("rep valid", valid, 1);
        check("rep out", out, 12'h4D2);
        check("rep err", err, 0);
        check("rep busy end", busy, 0);
        start = 1'b0;
        @(negedge clk);
        check("rep ignored valid", valid, 0);
        check("rep ignored busy", busy, 0);

        // Reset during a conversion: immediate clear, no VALID, then normal recovery.
        @(negedge clk);
        drive(0, 7, 8, 9);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst out", out, 0);
        check("rst busy", busy, 0);
        check("rst valid", valid, 0);
        check("rst err", err, 0);
        saw_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            saw_valid |= valid;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            saw_valid |= valid | busy;
        end
        check("rst no valid", saw_valid, 0);
        convert('{"v0042", 0, 0, 4, 2, 12'h02A, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
